// File: rtl/fei4_rx_arbiter.sv
// ---------------------------------------------------------------------------
// fei4_rx_arbiter
//   Round-robin readout scheduler for NCH fei4_rx_core FIFO outputs. Words are
//   popped from enabled, non-empty first-word-fall-through FIFOs in bursts of
//   at most MAX_BURST words per grant and merged into one valid/ready stream.
//   All rx core FIFO_CLKs run on BUS_CLK.
//
// Parameters
//   NCH        number of rx channels (2..16)
//   MAX_BURST  max consecutive pops per grant (1..255)
//   CW         grant index width, clog2(NCH)
//
// Ports
//   BUS_CLK        in   clock
//   RST            in   synchronous active-high reset
//   CH_ENABLE      in   [NCH]     per-channel arbitration enable
//   RX_FIFO_EMPTY  in   [NCH]     rx core FIFO empty flags
//   RX_FIFO_DATA   in   [NCH*32]  rx core FIFO heads, ch i at [32*i+31:32*i]
//   RX_FIFO_READ   out  [NCH]     pop strobes (combinational, only GRANT bit)
//   OUT_DATA       out  [32]      merged data word
//   OUT_VALID      out            OUT_DATA valid
//   OUT_READY      in             downstream accept
//   GRANT          out  [CW]      currently granted channel
//   BUSY           out            arbiter is serving a burst
//   WORD_CNT       out  [32]      words accepted downstream, wrapping
// ---------------------------------------------------------------------------

// Per-channel slice: eligibility for arbitration and gated pop strobe.
module fei4_rx_arb_lane (
    input  logic en_i,
    input  logic empty_i,
    input  logic sel_i,
    input  logic pop_i,
    output logic elig_o,
    output logic read_o
);
    assign elig_o = en_i & ~empty_i;
    assign read_o = sel_i & pop_i;
endmodule

module fei4_rx_arbiter #(
    parameter int NCH       = 4,
    parameter int MAX_BURST = 16,
    parameter int CW        = 2
) (
    input  logic              BUS_CLK,
    input  logic              RST,
    input  logic [NCH-1:0]    CH_ENABLE,
    input  logic [NCH-1:0]    RX_FIFO_EMPTY,
    input  logic [NCH*32-1:0] RX_FIFO_DATA,
    output logic [NCH-1:0]    RX_FIFO_READ,
    output logic [31:0]       OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [CW-1:0]     GRANT,
    output logic              BUSY,
    output logic [31:0]       WORD_CNT
);

    typedef enum logic {ARB = 1'b0, SERVE = 1'b1} state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   last_q, last_d;
    logic [7:0]      burst_q, burst_d;
    logic [31:0]     out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     word_cnt_q, word_cnt_d;

    logic [NCH-1:0][31:0] rx_data;
    logic [NCH-1:0]       elig;
    logic [NCH-1:0]       sel;
    logic                 sel_elig;
    logic [31:0]          sel_data;
    logic                 pop;
    logic                 accept;
    logic                 rr_found;
    logic [CW-1:0]        rr_pick;

    assign rx_data = RX_FIFO_DATA;

    // Per-channel eligibility and pop strobe fan-out.
    for (genvar i = 0; i < NCH; i++) begin : g_lane
        assign sel[i] = (grant_q == CW'(i));
        fei4_rx_arb_lane u_lane (
            .en_i    (CH_ENABLE[i]),
            .empty_i (RX_FIFO_EMPTY[i]),
            .sel_i   (sel[i]),
            .pop_i   (pop),
            .elig_o  (elig[i]),
            .read_o  (RX_FIFO_READ[i])
        );
    end

    // Granted channel is enabled and has a word at its FIFO head.
    assign sel_elig = |(sel & elig);

    // One-hot mux of the granted FIFO head.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel[i]) sel_data = rx_data[i];
        end
    end

    // A pop may coincide with the downstream taking the held word, which
    // gives one word per cycle within a burst. RST suppresses the strobe so
    // no word leaves a FIFO while the output register is being cleared.
    assign pop    = (state_q == SERVE) & sel_elig & (~out_valid_q | OUT_READY) & ~RST;
    assign accept = out_valid_q & OUT_READY;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        logic [CW-1:0] idx;
        idx      = '0;
        rr_found = 1'b0;
        rr_pick  = grant_q;
        for (int k = 1; k <= NCH; k++) begin
            idx = CW'((int'(last_q) + k) % NCH);
            if (!rr_found && elig[idx]) begin
                rr_found = 1'b1;
                rr_pick  = idx;
            end
        end
    end

    // Next-state / datapath.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        burst_d     = burst_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        word_cnt_d  = word_cnt_q + {31'd0, accept};

        case (state_q)
            ARB: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    last_d  = rr_pick;
                    burst_d = '0;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (pop) begin
                    burst_d = burst_q + 8'd1;
                    if (burst_q == BURST_LAST) state_d = ARB;
                end else if (!sel_elig) begin
                    // FIFO drained or channel disabled: release the grant.
                    state_d = ARB;
                end
                // Stall (valid held, not ready) falls through: all hold.
            end
            default: state_d = ARB;
        endcase

        if (pop) begin
            out_data_d  = sel_data;
            out_valid_d = 1'b1;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state_q     <= ARB;
            grant_q     <= '0;
            last_q      <= CW'(NCH - 1);
            burst_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            burst_q     <= burst_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign GRANT     = grant_q;
    assign BUSY      = (state_q == SERVE);
    assign WORD_CNT  = word_cnt_q;

endmodule
